// File: rtl/rvm_mem_arbiter.sv
// Arbitrates the core's instruction and data ports onto one AXI4-Lite master, one transaction at a time.
// Optional RVM_ARB_ROUND_ROBIN_EN: alternate grants on ties; default build gives data fixed priority.
//
// state     | meaning
// ----------+----------------------------------------------
// S_IDLE    | no transaction; grant one requesting port
// S_RD_ADDR | arvalid asserted, waiting for arready
// S_RD_DATA | rready asserted, waiting for rvalid
// S_WR      | awvalid/wvalid asserted, each waits for its ready
// S_WR_RESP | bready asserted, waiting for bvalid
// S_RESP    | one-cycle rvalid pulse to the owning port
module rvm_mem_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                    clock_i,
   input  logic                    reset_ni,
   input  logic                    instr_req_i,
   input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
   output logic                    instr_gnt_o,
   output logic                    instr_rvalid_o,
   output logic [DATA_WIDTH-1:0]   instr_rdata_o,
   output logic                    instr_err_o,
   input  logic                    data_req_i,
   input  logic                    data_we_i,
   input  logic [ADDR_WIDTH-1:0]   data_addr_i,
   input  logic [DATA_WIDTH/8-1:0] data_be_i,
   input  logic [DATA_WIDTH-1:0]   data_wdata_i,
   output logic                    data_gnt_o,
   output logic                    data_rvalid_o,
   output logic                    data_err_o,
   output logic [DATA_WIDTH-1:0]   data_rdata_o,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [2:0]              m_axi_awprot,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   input  logic [1:0]              m_axi_bresp,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [2:0]              m_axi_arprot,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR, S_WR_RESP, S_RESP
   } state_t;

   state_t                  state_q;
   logic                    owner_data_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [2:0]              prot_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH/8-1:0] strb_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic                    err_q;
   logic                    instr_rvalid_q;
   logic                    data_rvalid_q;
   logic                    awvalid_q;
   logic                    wvalid_q;
   logic                    arvalid_q;
   logic                    bready_q;
   logic                    rready_q;
   logic                    pick_data;
   logic                    idle;

   assign idle = (state_q == S_IDLE);

`ifdef RVM_ARB_ROUND_ROBIN_EN
   logic last_data_q;

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         last_data_q <= 1'b0;
      end else if (idle && (instr_req_i || data_req_i)) begin
         last_data_q <= pick_data;
      end
   end

   // On a tie the port not granted last wins; last_data_q resets to instr so data wins first.
   assign pick_data = data_req_i && (!instr_req_i || !last_data_q);
`else
   assign pick_data = data_req_i;
`endif

   assign data_gnt_o  = idle && pick_data;
   assign instr_gnt_o = idle && instr_req_i && !pick_data;

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q        <= S_IDLE;
         owner_data_q   <= 1'b0;
         addr_q         <= '0;
         prot_q         <= 3'b000;
         wdata_q        <= '0;
         strb_q         <= '0;
         rdata_q        <= '0;
         err_q          <= 1'b0;
         instr_rvalid_q <= 1'b0;
         data_rvalid_q  <= 1'b0;
         awvalid_q      <= 1'b0;
         wvalid_q       <= 1'b0;
         arvalid_q      <= 1'b0;
         bready_q       <= 1'b0;
         rready_q       <= 1'b0;
      end else begin
         instr_rvalid_q <= 1'b0;
         data_rvalid_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (data_gnt_o || instr_gnt_o) begin
                  owner_data_q <= data_gnt_o;
                  addr_q       <= data_gnt_o ? data_addr_i : instr_addr_i;
                  prot_q       <= data_gnt_o ? 3'b000 : 3'b100;
                  wdata_q      <= data_gnt_o ? data_wdata_i : '0;
                  strb_q       <= data_gnt_o ? data_be_i : '0;
                  if (data_gnt_o && data_we_i) begin
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state_q   <= S_WR;
                  end else begin
                     arvalid_q <= 1'b1;
                     state_q   <= S_RD_ADDR;
                  end
               end
            end
            S_RD_ADDR: begin
               if (m_axi_arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= S_RD_DATA;
               end
            end
            S_RD_DATA: begin
               if (m_axi_rvalid) begin
                  rready_q       <= 1'b0;
                  rdata_q        <= m_axi_rdata;
                  err_q          <= (m_axi_rresp != 2'b00);
                  data_rvalid_q  <= owner_data_q;
                  instr_rvalid_q <= !owner_data_q;
                  state_q        <= S_RESP;
               end
            end
            S_WR: begin
               if (m_axi_awready) awvalid_q <= 1'b0;
               if (m_axi_wready)  wvalid_q  <= 1'b0;
               // A channel is finished if it already handshook or handshakes this cycle.
               if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
                  bready_q <= 1'b1;
                  state_q  <= S_WR_RESP;
               end
            end
            S_WR_RESP: begin
               if (m_axi_bvalid) begin
                  bready_q       <= 1'b0;
                  rdata_q        <= '0;
                  err_q          <= (m_axi_bresp != 2'b00);
                  data_rvalid_q  <= owner_data_q;
                  instr_rvalid_q <= !owner_data_q;
                  state_q        <= S_RESP;
               end
            end
            S_RESP: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign instr_rvalid_o = instr_rvalid_q;
   assign instr_rdata_o  = rdata_q;
   assign instr_err_o    = err_q;
   assign data_rvalid_o  = data_rvalid_q;
   assign data_rdata_o   = rdata_q;
   assign data_err_o     = err_q;

   assign m_axi_awaddr  = addr_q;
   assign m_axi_awprot  = prot_q;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = strb_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = bready_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arprot  = prot_q;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_rvm_mem_arbiter.sv
// Directed bench for rvm_mem_arbiter: a vector table of single transactions plus
// hand-written sequences for write skew, ties, backpressure and reset mid-transaction.
module tb_rvm_mem_arbiter;

   logic        clock_i = 1'b0;
   logic        reset_ni;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o;
   logic        instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        instr_err_o;
   logic        data_req_i;
   logic        data_we_i;
   logic [31:0] data_addr_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_wdata_i;
   logic        data_gnt_o;
   logic        data_rvalid_o;
   logic        data_err_o;
   logic [31:0] data_rdata_o;
   logic [31:0] m_axi_awaddr;
   logic [2:0]  m_axi_awprot;
   logic        m_axi_awvalid;
   logic        m_axi_awready;
   logic [31:0] m_axi_wdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_wvalid;
   logic        m_axi_wready;
   logic [1:0]  m_axi_bresp;
   logic        m_axi_bvalid;
   logic        m_axi_bready;
   logic [31:0] m_axi_araddr;
   logic [2:0]  m_axi_arprot;
   logic        m_axi_arvalid;
   logic        m_axi_arready;
   logic [31:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;
   logic        m_axi_rvalid;
   logic        m_axi_rready;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clock_i = ~clock_i;

   rvm_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clock_i(clock_i), .reset_ni(reset_ni),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
      .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
      .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
      .data_rvalid_o(data_rvalid_o), .data_err_o(data_err_o), .data_rdata_o(data_rdata_o),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
      .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
      .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready)
   );

   typedef struct {
      bit          is_instr;
      bit          we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] slv_rdata;
      logic [1:0]  resp;
      logic [31:0] exp_rdata;
      bit          exp_err;
   } vec_t;

   vec_t vecs[6];

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Zero-wait read; starts the cycle after the grant and ends on the response cycle.
   task automatic serve_read(input bit is_instr, input logic [31:0] addr, input logic [31:0] rdata,
                             input logic [1:0] resp, input bit exp_err, input bit hold);
      @(negedge clock_i);
      if (!hold) begin
         instr_req_i = 1'b0;
         data_req_i  = 1'b0;
      end
      m_axi_arready = 1'b1;
      #1;
      chk1("arvalid_t1", m_axi_arvalid, 1'b1);
      chk32("araddr", m_axi_araddr, addr);
      chk32("arprot", 32'(m_axi_arprot), is_instr ? 32'h4 : 32'h0);
      chk1("no_gnt_busy_i", instr_gnt_o, 1'b0);
      chk1("no_gnt_busy_d", data_gnt_o, 1'b0);
      @(negedge clock_i);
      m_axi_arready = 1'b0;
      m_axi_rvalid  = 1'b1;
      m_axi_rdata   = rdata;
      m_axi_rresp   = resp;
      #1;
      chk1("arvalid_t2", m_axi_arvalid, 1'b0);
      chk1("rready_t2", m_axi_rready, 1'b1);
      @(negedge clock_i);
      m_axi_rvalid = 1'b0;
      m_axi_rresp  = 2'b00;
      #1;
      chk1("rready_t3", m_axi_rready, 1'b0);
      chk1("instr_rvalid_t3", instr_rvalid_o, is_instr);
      chk1("data_rvalid_t3", data_rvalid_o, !is_instr);
      chk32("rdata_t3", is_instr ? instr_rdata_o : data_rdata_o, rdata);
      chk1("err_t3", is_instr ? instr_err_o : data_err_o, exp_err);
      chk1("no_gnt_resp", instr_gnt_o | data_gnt_o, 1'b0);
   endtask

   task automatic serve_write(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata,
                              input logic [1:0] resp, input bit exp_err);
      @(negedge clock_i);
      data_req_i    = 1'b0;
      m_axi_awready = 1'b1;
      m_axi_wready  = 1'b1;
      #1;
      chk1("awvalid_t1", m_axi_awvalid, 1'b1);
      chk1("wvalid_t1", m_axi_wvalid, 1'b1);
      chk32("awaddr", m_axi_awaddr, addr);
      chk32("wdata", m_axi_wdata, wdata);
      chk32("wstrb", 32'(m_axi_wstrb), 32'(be));
      chk32("awprot", 32'(m_axi_awprot), 32'h0);
      @(negedge clock_i);
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      m_axi_bvalid  = 1'b1;
      m_axi_bresp   = resp;
      #1;
      chk1("awvalid_t2", m_axi_awvalid, 1'b0);
      chk1("wvalid_t2", m_axi_wvalid, 1'b0);
      chk1("bready_t2", m_axi_bready, 1'b1);
      @(negedge clock_i);
      m_axi_bvalid = 1'b0;
      m_axi_bresp  = 2'b00;
      #1;
      chk1("bready_t3", m_axi_bready, 1'b0);
      chk1("data_rvalid_w", data_rvalid_o, 1'b1);
      chk1("instr_rvalid_w", instr_rvalid_o, 1'b0);
      chk32("rdata_w", data_rdata_o, 32'h0);
      chk1("err_w", data_err_o, exp_err);
   endtask

   initial begin
      bit exp_d;

      vecs[0] = '{1'b1, 1'b0, 32'h0000_1000, 4'h0, 32'h0, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 32'h2000_0000, 4'hF, 32'h0, 32'h0BAD_F00D, 2'b00, 32'h0BAD_F00D, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 32'h2000_0008, 4'hF, 32'h0, 32'h1111_2222, 2'b10, 32'h1111_2222, 1'b1};
      vecs[3] = '{1'b0, 1'b1, 32'h2000_0004, 4'b0011, 32'h1234_5678, 32'h0, 2'b00, 32'h0, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 32'h2000_000C, 4'b1100, 32'hAABB_CCDD, 32'h0, 2'b11, 32'h0, 1'b1};
      vecs[5] = '{1'b1, 1'b0, 32'h0000_2004, 4'h0, 32'h0, 32'h5555_AAAA, 2'b01, 32'h5555_AAAA, 1'b1};

      reset_ni = 1'b0;
      instr_req_i = 1'b0; instr_addr_i = '0;
      data_req_i = 1'b0; data_we_i = 1'b0; data_addr_i = '0; data_be_i = '0; data_wdata_i = '0;
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
      m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rvalid = 1'b0;

      #12;
      chk1("rst_arvalid", m_axi_arvalid, 1'b0);
      chk1("rst_awvalid", m_axi_awvalid, 1'b0);
      chk1("rst_wvalid", m_axi_wvalid, 1'b0);
      chk1("rst_bready", m_axi_bready, 1'b0);
      chk1("rst_rready", m_axi_rready, 1'b0);
      chk1("rst_instr_rvalid", instr_rvalid_o, 1'b0);
      chk1("rst_data_rvalid", data_rvalid_o, 1'b0);
      chk32("rst_araddr", m_axi_araddr, 32'h0);
      chk32("rst_wdata", m_axi_wdata, 32'h0);
      chk32("rst_rdata", instr_rdata_o, 32'h0);
      @(negedge clock_i);
      reset_ni = 1'b1;

      for (int i = 0; i < 6; i++) begin
         @(negedge clock_i);
         instr_req_i  = vecs[i].is_instr;
         instr_addr_i = vecs[i].addr;
         data_req_i   = !vecs[i].is_instr;
         data_we_i    = vecs[i].we;
         data_addr_i  = vecs[i].addr;
         data_be_i    = vecs[i].be;
         data_wdata_i = vecs[i].wdata;
         #1;
         chk1("vec_instr_gnt", instr_gnt_o, vecs[i].is_instr);
         chk1("vec_data_gnt", data_gnt_o, !vecs[i].is_instr);
         if (vecs[i].we)
            serve_write(vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].resp, vecs[i].exp_err);
         else
            serve_read(vecs[i].is_instr, vecs[i].addr, vecs[i].slv_rdata, vecs[i].resp,
                       vecs[i].exp_err, 1'b0);
         @(negedge clock_i);
         #1;
         chk1("vec_pulse_end_i", instr_rvalid_o, 1'b0);
         chk1("vec_pulse_end_d", data_rvalid_o, 1'b0);
      end

      // Write with wready two cycles after awready.
      @(negedge clock_i);
      data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h2000_0004;
      data_be_i = 4'b0011; data_wdata_i = 32'h1234_5678;
      #1;
      chk1("skew_gnt", data_gnt_o, 1'b1);
      @(negedge clock_i);
      data_req_i = 1'b0; m_axi_awready = 1'b1;
      #1;
      chk1("skew_aw_t1", m_axi_awvalid, 1'b1);
      chk1("skew_w_t1", m_axi_wvalid, 1'b1);
      @(negedge clock_i);
      m_axi_awready = 1'b0;
      #1;
      chk1("skew_aw_t2", m_axi_awvalid, 1'b0);
      chk1("skew_w_t2", m_axi_wvalid, 1'b1);
      chk1("skew_bready_t2", m_axi_bready, 1'b0);
      @(negedge clock_i);
      m_axi_wready = 1'b1;
      #1;
      chk1("skew_w_t3", m_axi_wvalid, 1'b1);
      chk32("skew_wdata_t3", m_axi_wdata, 32'h1234_5678);
      @(negedge clock_i);
      m_axi_wready = 1'b0; m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
      #1;
      chk1("skew_w_t4", m_axi_wvalid, 1'b0);
      chk1("skew_bready_t4", m_axi_bready, 1'b1);
      @(negedge clock_i);
      m_axi_bvalid = 1'b0;
      #1;
      chk1("skew_rvalid", data_rvalid_o, 1'b1);
      chk1("skew_err", data_err_o, 1'b0);
      chk1("skew_instr_rvalid", instr_rvalid_o, 1'b0);
      @(negedge clock_i);
      #1;
      chk1("skew_pulse_end", data_rvalid_o, 1'b0);

      // Both ports held high across three transactions.
      @(negedge clock_i);
      instr_req_i = 1'b1; instr_addr_i = 32'h0000_3000;
      data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h0000_4000;
      for (int t = 0; t < 3; t++) begin
         if (t > 0) @(negedge clock_i);
         #1;
`ifdef RVM_ARB_ROUND_ROBIN_EN
         exp_d = (t != 1);
`else
         exp_d = 1'b1;
`endif
         chk1("tie_data_gnt", data_gnt_o, exp_d);
         chk1("tie_instr_gnt", instr_gnt_o, !exp_d);
         serve_read(!exp_d, exp_d ? 32'h0000_4000 : 32'h0000_3000, 32'hA000_0000 + 32'(t),
                    2'b00, 1'b0, t < 2);
      end
      @(negedge clock_i);
      #1;
      chk1("tie_idle_gnt", instr_gnt_o | data_gnt_o, 1'b0);

      // arready held low for 10 cycles; instr_req stays high to expose any second grant.
      @(negedge clock_i);
      instr_req_i = 1'b1; instr_addr_i = 32'h5000_0010;
      #1;
      chk1("bp_gnt", instr_gnt_o, 1'b1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clock_i);
         instr_addr_i = 32'hFFFF_FFFF;
         #1;
         chk1("bp_arvalid", m_axi_arvalid, 1'b1);
         chk32("bp_araddr", m_axi_araddr, 32'h5000_0010);
         chk1("bp_no_gnt", instr_gnt_o, 1'b0);
      end
      @(negedge clock_i);
      instr_req_i = 1'b0; m_axi_arready = 1'b1;
      #1;
      chk1("bp_arvalid_hs", m_axi_arvalid, 1'b1);
      @(negedge clock_i);
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b1; m_axi_rdata = 32'hCAFE_F00D;
      #1;
      chk1("bp_rready", m_axi_rready, 1'b1);
      @(negedge clock_i);
      m_axi_rvalid = 1'b0;
      #1;
      chk1("bp_rvalid", instr_rvalid_o, 1'b1);
      chk32("bp_rdata", instr_rdata_o, 32'hCAFE_F00D);

      // Reset while waiting in RD_DATA.
      @(negedge clock_i);
      instr_req_i = 1'b1; instr_addr_i = 32'h0000_6000;
      #1;
      chk1("rw_gnt", instr_gnt_o, 1'b1);
      @(negedge clock_i);
      instr_req_i = 1'b0; m_axi_arready = 1'b1;
      @(negedge clock_i);
      m_axi_arready = 1'b0;
      #1;
      chk1("rw_rready_before", m_axi_rready, 1'b1);
      #2;
      reset_ni = 1'b0;
      #1;
      chk1("rw_rready", m_axi_rready, 1'b0);
      chk1("rw_arvalid", m_axi_arvalid, 1'b0);
      chk1("rw_instr_rvalid", instr_rvalid_o, 1'b0);
      chk32("rw_rdata", instr_rdata_o, 32'h0);
      chk32("rw_araddr", m_axi_araddr, 32'h0);
      @(negedge clock_i);
      reset_ni = 1'b1;
      @(negedge clock_i);
      instr_req_i = 1'b1; instr_addr_i = 32'h0000_7000;
      #1;
      chk1("rw_regnt", instr_gnt_o, 1'b1);
      serve_read(1'b1, 32'h0000_7000, 32'h1357_9BDF, 2'b00, 1'b0, 1'b0);

      @(negedge clock_i);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
